// File: rtl/pipeline_result_buffer.sv
// pipeline_result_buffer: captures pipelined results into a FIFO with drop tracking and a running sum
module pipeline_result_buffer #(
  parameter int LATENCY = 3,
  parameter int DEPTH   = 4,
  parameter int WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   issue_valid,
  input  logic [WIDTH-1:0]       f,
  input  logic                   acc_clr,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   overflow,
  output logic [7:0]             drop_cnt,
  output logic [15:0]            acc
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];
  logic [LATENCY-1:0] r_vld;
  logic [LATENCY:0]   w_vld_nxt;
  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [AW-1:0]      r_wp;
  logic [AW-1:0]      r_rp;
  logic [AW:0]        r_level;
  logic               r_ovf;
  logic [7:0]         r_drop;
  logic [15:0]        r_acc;
  logic               w_cap;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  assign w_vld_nxt = {r_vld, issue_valid};
  assign w_cap     = r_vld[LATENCY-1];
  assign full      = r_level == FULL_LVL;
  assign out_valid = r_level != '0;
  assign w_pop     = out_valid && out_ready;
  assign w_push    = w_cap && (!full || w_pop);
  assign w_drop    = w_cap && !w_push;
  assign out_data  = r_mem[r_rp];
  assign level     = r_level;
  assign overflow  = r_ovf;
  assign drop_cnt  = r_drop;
  assign acc       = r_acc;
  // Track issues down the pipeline, move FIFO pointers/occupancy, and account drops and the sum
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld   <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
      r_drop  <= '0;
      r_acc   <= '0;
    end else begin
      r_vld   <= w_vld_nxt[LATENCY-1:0];
      r_wp    <= r_wp + AW'(w_push);
      r_rp    <= r_rp + AW'(w_pop);
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
      r_ovf   <= r_ovf | w_drop;
      r_drop  <= r_drop + 8'(w_drop && r_drop != 8'hff);
      r_acc   <= (acc_clr ? 16'd0 : r_acc) + (w_push ? 16'(f) : 16'd0);
    end
  end
  // Store each accepted result at the write pointer; storage itself is never cleared
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= f;
  end
endmodule

// File: doc/pipeline_result_buffer.md
PIPELINE_RESULT_BUFFER -- requirements
Module: pipeline_result_buffer

Interface
REQ-001 Parameter LATENCY, default 3: cycles from operand issue to the upstream f register holding the result.
REQ-002 Parameter DEPTH, default 4: result FIFO entries, power of two, minimum 2.
REQ-003 Parameter WIDTH, default 8: result width, matches upstream f.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 issue_valid  input  1  high in the cycle operands a/b/c/d are presented to the upstream pipeline.
REQ-007 f  input  WIDTH  upstream pipeline result.
REQ-008 acc_clr  input  1  synchronous clear of accumulator only.
REQ-009 out_ready  input  1  downstream consumer accepts out_data this cycle.
REQ-010 out_valid  output  1  out_data holds the oldest buffered result.
REQ-011 out_data  output  WIDTH  oldest buffered result.
REQ-012 level  output  clog2(DEPTH)+1  FIFO occupancy.
REQ-013 full  output  1  level == DEPTH.
REQ-014 overflow  output  1  sticky: at least one result dropped since reset.
REQ-015 drop_cnt  output  8  dropped-result count, saturating at 255.
REQ-016 acc  output  16  modulo-2^16 sum of all results written into the FIFO.

Function
REQ-017 Valid tracking: a LATENCY-stage shift register, fed by issue_valid and advancing every cycle; its last stage is cap.
REQ-018 Capture: on the edge where cap=1, f is sampled (issue at edge k -> capture at edge k+LATENCY); at LATENCY=3, back-to-back issues capture on consecutive edges.
REQ-019 Pop: occurs on an edge where out_valid=1 and out_ready=1.
REQ-020 Push: a capture is pushed if level<DEPTH, or if level==DEPTH and a pop occurs the same edge.
REQ-021 Drop: a capture is dropped if level==DEPTH and no pop occurs; drop sets overflow and increments drop_cnt (holds at 255).
REQ-022 Empty FIFO, simultaneous capture and out_ready=1: no bypass; value is pushed; out_valid rises the next cycle.
REQ-023 out_valid = (level != 0); out_data driven from storage at the read pointer; out_data is stable while out_valid=1 and out_ready=0.
REQ-024 level: +1 on push without pop; -1 on pop without push; unchanged on both or neither.
REQ-025 Pointers: wrap modulo DEPTH; order strictly first in, first out.
REQ-026 Accumulator: on each push, acc <= acc + f (zero-extended), wraps modulo 2^16.
REQ-027 Dropped results are never added to acc.
REQ-028 acc_clr=1: acc <= 0; a same-edge push sets acc to that f.
REQ-029 out_ready while out_valid=0: ignored, no state change.

Reset
REQ-030 rst_n=0 at an edge: shift register, pointers, level, overflow, drop_cnt and acc all go to 0; out_valid=0, full=0.
REQ-031 FIFO storage contents need no reset; out_data is don't-care while out_valid=0.
REQ-032 Reset mid-flight: issues in the shift register are discarded and never captured.
REQ-033 Reset priority: reset overrides issue_valid, acc_clr and out_ready in the same cycle.
REQ-034 Exit from reset: the first edge with rst_n=1 samples issue_valid normally.

Verification
REQ-035 Bench instantiates the upstream pipeline and this block with default parameters; issue_valid accompanies each operand set.
REQ-036 Back-to-back issue, out_ready=1:
- Stimulus: operands (10,5,20,3), (8,12,6,2), (15,7,10,4), (1,2,3,1) issued on edges 1-4.
- Response: out_data 96, 48, 112, 5 on consecutive cycles; first out_valid after edge 4; acc=261; drop_cnt=0.
REQ-037 Overflow:
- Stimulus: out_ready=0; six consecutive issues of (1,2,3,1), each result 5.
- Response: level=4, full=1, drop_cnt=2, overflow=1, acc=20.
- Then out_ready=1: four results of 5, then out_valid=0; overflow stays 1.
REQ-038 Full with simultaneous pop and capture:
- Stimulus: FIFO full; out_ready=1 on the edge a capture arrives.
- Response: no drop; level stays 4; order preserved.
REQ-039 Reset mid-flight:
- Stimulus: issue (10,5,20,3) at edge k; rst_n=0 at edge k+1 only.
- Response: nothing captured; out_valid=0, level=0, acc=0 through edge k+5.
REQ-040 Accumulator wrap and clear:
- Stimulus: 257 results of 255 pushed with continuous pop.
- Response: acc = 65535 + 0 wraps to 65535 after 257 pushes (257*255 = 65535).
- One further 255 -> acc=254; acc_clr with a same-edge push of 5 -> acc=5.
